// File: rtl/display_frame_sequencer.sv
// ---------------------------------------------------------------------------
// display_frame_sequencer
//
// Walks the display rows of one frame in order. For each row it addresses
// the background and foreground row sources, merges them under the
// foreground mask into a row buffer, and then streams that buffer to the
// display link as WORD_W-bit words over a valid/ready handshake.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   frame_start  one-cycle frame request (ignored while busy)
//   row_idx      row addressed on both row sources
//   bg_row       background row at row_idx (pixel 0 = bit 0)
//   fg_row       foreground row at row_idx
//   fg_mask      1 = foreground pixel wins
//   out_data     pixel word, leftmost pixel in MSB
//   out_valid    out_data valid
//   out_ready    downstream accepts the word
//   out_sol      word 0 of a row
//   out_eof      last word of the frame
//   busy         frame in progress
//   frame_done   one-cycle pulse at frame completion
//   overrun      one-cycle pulse after frame_start arrives while busy
// ---------------------------------------------------------------------------
module display_frame_sequencer #(
   parameter int ROWS   = 40,
   parameter int ROW_W  = 256,
   parameter int WORD_W = 32
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  frame_start,
   output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] row_idx,
   input  logic [0:ROW_W-1]                      bg_row,
   input  logic [0:ROW_W-1]                      fg_row,
   input  logic [0:ROW_W-1]                      fg_mask,
   output logic [WORD_W-1:0]                     out_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic                                  out_sol,
   output logic                                  out_eof,
   output logic                                  busy,
   output logic                                  frame_done,
   output logic                                  overrun
);

   localparam int WPR = ROW_W / WORD_W;
   localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int KW  = (WPR > 1) ? $clog2(WPR) : 1;
   localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
   localparam logic [KW-1:0] LAST_WORD = KW'(WPR - 1);

   typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

   state_t              state_q, state_d;
   logic [RW-1:0]       row_q, row_d;
   logic [KW-1:0]       word_q, word_d;
   logic [0:ROW_W-1]    row_buf_q, row_buf_d;
   logic [WORD_W-1:0]   out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                out_sol_q, out_sol_d;
   logic                out_eof_q, out_eof_d;
   logic                busy_q, busy_d;
   logic                frame_done_q, frame_done_d;
   logic                overrun_q, overrun_d;

   logic [0:ROW_W-1]    composite;
   logic                xfer;
   logic [KW-1:0]       word_inc;

   // Word k covers pixels k*WORD_W .. k*WORD_W+WORD_W-1; the ascending
   // slice lands with its leftmost pixel in the MSB of the result.
   function automatic logic [WORD_W-1:0] word_of(input logic [0:ROW_W-1] r,
                                                 input logic [KW-1:0]    k);
      return r[int'(k)*WORD_W +: WORD_W];
   endfunction

   assign composite = (fg_row & fg_mask) | (bg_row & ~fg_mask);
   assign xfer      = out_valid_q && out_ready;
   assign word_inc  = word_q + 1'b1;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         row_q        <= '0;
         word_q       <= '0;
         row_buf_q    <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_sol_q    <= 1'b0;
         out_eof_q    <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         word_q       <= word_d;
         row_buf_q    <= row_buf_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_sol_q    <= out_sol_d;
         out_eof_q    <= out_eof_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (frame_start) state_d = FETCH;
         FETCH: state_d = SEND;
         SEND: begin
            if (xfer && (word_q == LAST_WORD)) begin
               state_d = (row_q == LAST_ROW) ? DONE : FETCH;
            end
         end
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output / datapath logic
   // Every output is computed one cycle ahead from state_d so that the
   // registered outputs line up with the state they describe.
   // ---------------------------------------------------------------------
   always_comb begin
      row_d      = row_q;
      word_d     = word_q;
      row_buf_d  = row_buf_q;
      out_data_d = out_data_q;
      out_sol_d  = out_sol_q;
      out_eof_d  = out_eof_q;

      unique case (state_q)
         IDLE: begin
            row_d = '0;
         end
         FETCH: begin
            // Sources are sampled here only; word 0 is presented straight
            // from the merge so SEND starts without an extra bubble.
            row_buf_d  = composite;
            word_d     = '0;
            out_data_d = word_of(composite, '0);
            out_sol_d  = 1'b1;
            out_eof_d  = (row_q == LAST_ROW) && (LAST_WORD == '0);
         end
         SEND: begin
            if (xfer) begin
               if (word_q != LAST_WORD) begin
                  word_d     = word_inc;
                  out_data_d = word_of(row_buf_q, word_inc);
                  out_sol_d  = 1'b0;
                  out_eof_d  = (row_q == LAST_ROW) && (word_inc == LAST_WORD);
               end else begin
                  out_sol_d = 1'b0;
                  out_eof_d = 1'b0;
                  if (row_q != LAST_ROW) row_d = row_q + 1'b1;
               end
            end
         end
         DONE: begin
         end
         default: begin
         end
      endcase

      out_valid_d  = (state_d == SEND);
      busy_d       = (state_d != IDLE);
      frame_done_d = (state_d == DONE);
      overrun_d    = frame_start && (state_q != IDLE);
   end

   assign row_idx    = row_q;
   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_sol    = out_sol_q;
   assign out_eof    = out_eof_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_display_frame_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for display_frame_sequencer: row sources are modelled as per-row
// memories indexed by row_idx; expected words are queued when a frame is
// requested and a monitor pops them on every handshake.
// ---------------------------------------------------------------------------
module tb_display_frame_sequencer;

   localparam int ROWS   = 40;
   localparam int ROW_W  = 256;
   localparam int WORD_W = 32;
   localparam int WPR    = ROW_W / WORD_W;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                frame_start = 1'b0;
   logic                out_ready = 1'b0;
   logic [5:0]          row_idx;
   logic [0:ROW_W-1]    bg_row, fg_row, fg_mask;
   logic [WORD_W-1:0]   out_data;
   logic                out_valid, out_sol, out_eof, busy, frame_done, overrun;

   logic [0:ROW_W-1]    bg_mem   [ROWS];
   logic [0:ROW_W-1]    fg_mem   [ROWS];
   logic [0:ROW_W-1]    mask_mem [ROWS];
   logic [0:ROW_W-1]    disturb = '0;

   assign bg_row  = (row_idx < ROWS) ? (bg_mem[row_idx] ^ disturb) : '0;
   assign fg_row  = (row_idx < ROWS) ? fg_mem[row_idx]   : '0;
   assign fg_mask = (row_idx < ROWS) ? mask_mem[row_idx] : '0;

   display_frame_sequencer #(.ROWS(ROWS), .ROW_W(ROW_W), .WORD_W(WORD_W)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .row_idx(row_idx),
      .bg_row(bg_row), .fg_row(fg_row), .fg_mask(fg_mask),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sol(out_sol), .out_eof(out_eof), .busy(busy),
      .frame_done(frame_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] data;
      logic        sol;
      logic        eof;
      int          row;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: each pixel independently picks fg or bg by its mask bit;
   // pixel p of word k sits at bit (31-p) of the word.
   function automatic logic [31:0] model_word(input int r, input int k);
      logic [31:0] w;
      for (int p = 0; p < WORD_W; p++) begin
         int x;
         x = k * WORD_W + p;
         w[WORD_W-1-p] = mask_mem[r][x] ? fg_mem[r][x] : bg_mem[r][x];
      end
      return w;
   endfunction

   task automatic push_model_frame();
      for (int r = 0; r < ROWS; r++)
         for (int k = 0; k < WPR; k++)
            sb.push_back('{model_word(r, k), (k == 0), (r == ROWS-1 && k == WPR-1), r});
   endtask

   task automatic fill_random();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < WPR; c++) begin
            bg_mem[r][c*32 +: 32]   = $urandom();
            fg_mem[r][c*32 +: 32]   = $urandom();
            mask_mem[r][c*32 +: 32] = $urandom();
         end
   endtask

   // ---------------- ready driver ----------------
   int rdy_mode = 0;
   int pat_cnt = 0;
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         1: begin out_ready = (pat_cnt % 3 == 0); pat_cnt++; end
         2: out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b1;
      endcase
   end

   // ---------------- monitor ----------------
   int   start_cyc, first_valid_cyc, eof_cyc, done_cyc, done_cnt, done_base;
   int   stall_cnt, xfer_cnt;
   int   ovr_q[$];
   logic prev_stall = 1'b0;
   logic [31:0] held_data;
   logic held_sol, held_eof;

   initial done_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, held_data);
            chk("stall_sol", out_sol, held_sol);
            chk("stall_eof", out_eof, held_eof);
         end
         if (out_valid && out_ready) begin
            xfer_cnt++;
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_word: got %0h, none expected (cycle %0d)", out_data, cyc);
            end else begin
               e = sb.pop_front();
               chk("word_data", out_data, e.data);
               chk("word_sol", out_sol, e.sol);
               chk("word_eof", out_eof, e.eof);
               chk("word_row", row_idx, e.row);
            end
            if (out_eof) eof_cyc = cyc;
         end
         prev_stall = out_valid && !out_ready;
         if (prev_stall) begin
            stall_cnt++;
            held_data = out_data;
            held_sol  = out_sol;
            held_eof  = out_eof;
         end
         if (frame_done) begin
            done_cyc = cyc;
            done_cnt++;
         end
         if (overrun) ovr_q.push_back(cyc);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_frame();
      @(posedge clk);
      #2;
      first_valid_cyc = -1;
      eof_cyc = -1;
      done_cyc = -1;
      stall_cnt = 0;
      xfer_cnt = 0;
      done_base = done_cnt;
      start_cyc = cyc;
      frame_start = 1'b1;
      @(posedge clk);
      #2;
      frame_start = 1'b0;
   endtask

   task automatic wait_frame(input int budget);
      int n;
      n = 0;
      while (done_cnt == done_base && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (done_cnt == done_base) begin
         n_chk++;
         n_fail++;
         $display("FAIL frame_timeout: no frame_done after %0d cycles", budget);
      end
   endtask

   task automatic check_frame(input string tag);
      chk({tag, "_first_word_cyc"}, first_valid_cyc - start_cyc, 2);
      chk({tag, "_transfers"}, xfer_cnt, ROWS * WPR);
      chk({tag, "_leftover"}, sb.size(), 0);
      chk({tag, "_eof_cyc"}, eof_cyc - start_cyc, 360 + stall_cnt);
      chk({tag, "_done_cyc"}, done_cyc - start_cyc, 361 + stall_cnt);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_row_idx"}, row_idx, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_sol"}, out_sol, 0);
      chk({tag, "_out_eof"}, out_eof, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
      chk({tag, "_overrun"}, overrun, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int s;
      for (int r = 0; r < ROWS; r++) begin
         bg_mem[r] = '0;
         fg_mem[r] = '0;
         mask_mem[r] = '0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Full frame, ready held high: word value equals its row index
      rdy_mode = 0;
      for (int r = 0; r < ROWS; r++) begin
         bg_mem[r] = '0;
         mask_mem[r] = '1;
         for (int c = 0; c < WPR; c++) fg_mem[r][c*32 +: 32] = 32'(r);
         for (int k = 0; k < WPR; k++)
            sb.push_back('{32'(r), (k == 0), (r == ROWS-1 && k == WPR-1), r});
      end
      start_frame();
      wait_frame(1000);
      check_frame("full");
      chk("full_no_stalls", stall_cnt, 0);

      // Mix: mask covers left half of word 0 only
      for (int r = 0; r < ROWS; r++) begin
         bg_mem[r] = '1;
         fg_mem[r] = '0;
         mask_mem[r] = '0;
         mask_mem[r][0 +: 16] = '1;
         for (int k = 0; k < WPR; k++)
            sb.push_back('{(k == 0) ? 32'h0000FFFF : 32'hFFFFFFFF,
                           (k == 0), (r == ROWS-1 && k == WPR-1), r});
      end
      start_frame();
      wait_frame(1000);
      check_frame("mix");

      // Backpressure pattern 1,0,0 with random pixels
      fill_random();
      push_model_frame();
      pat_cnt = 0;
      rdy_mode = 1;
      start_frame();
      wait_frame(3000);
      check_frame("bp");
      rdy_mode = 0;

      // Overrun: requests at +50 and +361 are ignored
      fill_random();
      push_model_frame();
      ovr_q.delete();
      start_frame();
      s = start_cyc;
      while (cyc != s + 50) begin @(posedge clk); #2; end
      frame_start = 1'b1;
      @(posedge clk); #2;
      frame_start = 1'b0;
      while (cyc != s + 361) begin @(posedge clk); #2; end
      frame_start = 1'b1;
      @(posedge clk); #2;
      frame_start = 1'b0;
      repeat (30) @(posedge clk);
      #2;
      chk("ovr_frames", done_cnt - done_base, 1);
      chk("ovr_transfers", xfer_cnt, ROWS * WPR);
      chk("ovr_leftover", sb.size(), 0);
      chk("ovr_done_cyc", done_cyc - s, 361);
      chk("ovr_pulses", ovr_q.size(), 2);
      if (ovr_q.size() == 2) begin
         chk("ovr_pulse0_cyc", ovr_q[0] - s, 51);
         chk("ovr_pulse1_cyc", ovr_q[1] - s, 362);
      end
      chk("ovr_busy_after", busy, 0);

      // Source change while row 5 streams, random ready
      fill_random();
      push_model_frame();
      rdy_mode = 2;
      start_frame();
      n = 0;
      do begin @(negedge clk); n++; end while (!(row_idx == 5 && out_valid) && n < 2000);
      disturb = '1;
      n = 0;
      do begin @(negedge clk); n++; end while (row_idx != 6 && n < 2000);
      disturb = '0;
      wait_frame(3000);
      check_frame("srcchg");
      rdy_mode = 0;

      // Asynchronous reset while row 17 word 3 is on the link
      fill_random();
      push_model_frame();
      start_frame();
      n = 0;
      do begin @(posedge clk); #3; n++; end while (xfer_cnt != 17 * WPR + 3 && n < 1000);
      chk("rst_mid_row", row_idx, 17);
      chk("rst_mid_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      sb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      fill_random();
      push_model_frame();
      start_frame();
      #1;
      chk("post_rst_row_idx", row_idx, 0);
      chk("post_rst_busy", busy, 1);
      wait_frame(1000);
      check_frame("post_rst");

      repeat (5) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
